// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the data-hazard scoreboard.
//  REG_ZERO  : register address that is hard-wired to zero; writes to it and
//              reads from it never create a hazard.
//  sel_width : width of a stage-index field; a single-stage scoreboard still
//              needs a 1-bit select port, which is simply tied to zero.
package hazard_scoreboard_pkg;

   localparam int REG_ZERO = 0;

   function automatic int sel_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/hazard_addr_cmp.sv
// Compares one decode source address against every scoreboard entry and
// reports the youngest (lowest index) valid entry that writes that register.
// Ports:
//  src_en   : source actually reads the register file this cycle
//  src_addr : source register address
//  sb_v     : valid bit of each in-flight write (index 0 = youngest)
//  sb_da    : destination address of each in-flight write
//  hit      : some valid entry writes src_addr
//  hit_idx  : index of the youngest such entry (0 when no hit)
module hazard_addr_cmp
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW     = 3,
   parameter int PIPE_DEPTH = 3
) (
   input  logic                                 src_en,
   input  logic [REG_AW-1:0]                    src_addr,
   input  logic [PIPE_DEPTH-1:0]                sb_v,
   input  logic [PIPE_DEPTH-1:0][REG_AW-1:0]    sb_da,
   output logic                                 hit,
   output logic [sel_width(PIPE_DEPTH)-1:0]     hit_idx
);

   localparam int SEL_W = sel_width(PIPE_DEPTH);

   logic [PIPE_DEPTH-1:0] eq_vec;
   logic                  src_live;

   // Register zero is constant, so reading it can never depend on a write.
   assign src_live = src_en & (src_addr != REG_AW'(REG_ZERO));

   always_comb begin
      eq_vec = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         eq_vec[k] = src_live & sb_v[k] & (sb_da[k] == src_addr);
      end
   end

   // Scan oldest to youngest so the last assignment, the youngest match,
   // wins: it holds the architecturally newest value of the register.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         if (eq_vec[k]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit between decode and the execute/writeback pipeline.
// A PIPE_DEPTH-entry shift scoreboard records in-flight register writes;
// each decode source is either forwarded from a stage whose result already
// exists or decode is stalled and a bubble enters stage 0.
// Ports:
//  clk, rst            : rising-edge clock, synchronous active-high reset
//  id_valid            : decode slot holds a valid instruction
//  id_aa, id_ba        : source A / B register addresses
//  id_ma, id_mb        : source A / B is a constant (no register read)
//  id_rw, id_da        : instruction writes register id_da
//  flush               : branch-taken kill of all in-flight writes
//  stall               : hold PC/decode, bubble into stage 0
//  issue               : decode instruction enters the pipeline
//  fwd_a_vld/fwd_a_sel : A taken from pipeline stage fwd_a_sel
//  fwd_b_vld/fwd_b_sel : B taken from pipeline stage fwd_b_sel
//  stall_cnt           : saturating count of stall cycles
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int REG_AW     = 3,
   parameter int PIPE_DEPTH = 3,
   parameter int FWD_EN     = 1,
   parameter int FWD_MIN    = 1,
   parameter int CNT_W      = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              id_valid,
   input  logic [REG_AW-1:0]                 id_aa,
   input  logic [REG_AW-1:0]                 id_ba,
   input  logic                              id_ma,
   input  logic                              id_mb,
   input  logic                              id_rw,
   input  logic [REG_AW-1:0]                 id_da,
   input  logic                              flush,
   output logic                              stall,
   output logic                              issue,
   output logic                              fwd_a_vld,
   output logic [sel_width(PIPE_DEPTH)-1:0]  fwd_a_sel,
   output logic                              fwd_b_vld,
   output logic [sel_width(PIPE_DEPTH)-1:0]  fwd_b_sel,
   output logic [CNT_W-1:0]                  stall_cnt
);

   localparam int SEL_W = sel_width(PIPE_DEPTH);

   logic [PIPE_DEPTH-1:0]             sb_v;
   logic [PIPE_DEPTH-1:0][REG_AW-1:0] sb_da;

   logic             a_hit;
   logic [SEL_W-1:0] a_idx;
   logic             b_hit;
   logic [SEL_W-1:0] b_idx;
   logic             a_block;
   logic             b_block;

   hazard_addr_cmp #(
      .REG_AW     (REG_AW),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) u_cmp_a (
      .src_en   (id_valid & ~id_ma),
      .src_addr (id_aa),
      .sb_v     (sb_v),
      .sb_da    (sb_da),
      .hit      (a_hit),
      .hit_idx  (a_idx)
   );

   hazard_addr_cmp #(
      .REG_AW     (REG_AW),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) u_cmp_b (
      .src_en   (id_valid & ~id_mb),
      .src_addr (id_ba),
      .sb_v     (sb_v),
      .sb_da    (sb_da),
      .hit      (b_hit),
      .hit_idx  (b_idx)
   );

   // A source blocks when its newest producer sits in a stage whose result
   // does not exist yet (or forwarding is disabled altogether). A flush kills
   // the decode instruction, so nothing needs holding and nothing is forwarded.
   always_comb begin
      a_block   = a_hit & ((FWD_EN == 0) || (int'(a_idx) < FWD_MIN));
      b_block   = b_hit & ((FWD_EN == 0) || (int'(b_idx) < FWD_MIN));
      stall     = ~flush & (a_block | b_block);
      issue     = id_valid & ~stall & ~flush;
      fwd_a_vld = ~flush & a_hit & ~a_block;
      fwd_b_vld = ~flush & b_hit & ~b_block;
      fwd_a_sel = fwd_a_vld ? a_idx : '0;
      fwd_b_sel = fwd_b_vld ? b_idx : '0;
   end

   // Older entries always advance; stage 0 records the issuing write only,
   // so a stall or flush shifts in a bubble. Flush also invalidates every
   // entry already in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_v <= '0;
      end else begin
         sb_v[0] <= issue & id_rw & (id_da != REG_AW'(REG_ZERO));
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            sb_v[k] <= ~flush & sb_v[k-1];
         end
      end
   end

   // Addresses are meaningless while the matching valid bit is low.
   always_ff @(posedge clk) begin
      sb_da[0] <= id_da;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
         sb_da[k] <= sb_da[k-1];
      end
   end

   // Saturating stall counter: holds at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule
